register_readback_serializer: RTL

Read-side companion to the storage register. It accepts a WIDTH-bit register word over a valid/ready load handshake. It then shifts the word out serially, MSB first, on a framed single-bit line, one bit every CLK_DIV clocks. It sits between register outputs and the debug/readback path, so stored values can be observed serially without exposing the full bus.

---
 rtl/register_readback_serializer.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/register_readback_serializer.sv
// Register readback serializer: accepts a WIDTH-bit word over a valid/ready
// handshake and shifts it out MSB first on a framed single-bit line, holding
// each bit for CLK_DIV clocks. All outputs come straight from flops.
module register_readback_serializer #(
    parameter int WIDTH   = 32,
    parameter int CLK_DIV = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    output logic             ser_data,
    output logic             ser_frame,
    output logic             busy,
    output logic             done
);

    localparam int BIT_W = $clog2(WIDTH);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_shift;
    logic [BIT_W-1:0]   r_bit_cnt;
    logic [DIV_W-1:0]   r_div_cnt;
    logic               r_load_ready;
    logic               r_ser_data;
    logic               r_ser_frame;
    logic               r_busy;
    logic               r_done;

    state_t             w_state_next;
    logic [WIDTH-1:0]   w_shift_next;
    logic [WIDTH-1:0]   w_shifted;
    logic [BIT_W-1:0]   w_bit_cnt_next;
    logic [DIV_W-1:0]   w_div_cnt_next;
    logic               w_load_ready_next;
    logic               w_ser_data_next;
    logic               w_ser_frame_next;
    logic               w_busy_next;
    logic               w_done_next;

    // The bit presented next is the MSB of the word after one more left shift.
    assign w_shifted = r_shift << 1;

    assign load_ready = r_load_ready;
    assign ser_data   = r_ser_data;
    assign ser_frame  = r_ser_frame;
    assign busy       = r_busy;
    assign done       = r_done;

    // State, datapath and output registers; reset clears everything at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_shift      <= '0;
            r_bit_cnt    <= '0;
            r_div_cnt    <= '0;
            r_load_ready <= 1'b0;
            r_ser_data   <= 1'b0;
            r_ser_frame  <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_shift      <= w_shift_next;
            r_bit_cnt    <= w_bit_cnt_next;
            r_div_cnt    <= w_div_cnt_next;
            r_load_ready <= w_load_ready_next;
            r_ser_data   <= w_ser_data_next;
            r_ser_frame  <= w_ser_frame_next;
            r_busy       <= w_busy_next;
            r_done       <= w_done_next;
        end
    end

    // Next-state and next-output logic; every register holds unless changed.
    always_comb begin
        w_state_next      = r_state;
        w_shift_next      = r_shift;
        w_bit_cnt_next    = r_bit_cnt;
        w_div_cnt_next    = r_div_cnt;
        w_load_ready_next = r_load_ready;
        w_ser_data_next   = r_ser_data;
        w_ser_frame_next  = r_ser_frame;
        w_busy_next       = r_busy;
        w_done_next       = r_done;

        case (r_state)
            IDLE: begin
                // load_ready only becomes visible one edge after reset release,
                // so a word can be taken only once the registered ready is high.
                w_load_ready_next = 1'b1;
                w_ser_frame_next  = 1'b0;
                w_ser_data_next   = 1'b0;
                w_busy_next       = 1'b0;
                w_done_next       = 1'b0;
                if (load_valid && r_load_ready) begin
                    w_state_next      = SHIFT;
                    w_shift_next      = load_data;
                    w_bit_cnt_next    = BIT_LAST;
                    w_div_cnt_next    = '0;
                    w_load_ready_next = 1'b0;
                    w_busy_next       = 1'b1;
                    w_ser_frame_next  = 1'b1;
                    w_ser_data_next   = load_data[WIDTH-1];
                end
            end

            SHIFT: begin
                if (r_div_cnt == DIV_LAST) begin
                    w_div_cnt_next = '0;
                    if (r_bit_cnt != '0) begin
                        w_shift_next    = w_shifted;
                        w_ser_data_next = w_shifted[WIDTH-1];
                        w_bit_cnt_next  = r_bit_cnt - BIT_W'(1);
                    end else begin
                        w_state_next     = DONE;
                        w_ser_frame_next = 1'b0;
                        w_ser_data_next  = 1'b0;
                        w_done_next      = 1'b1;
                    end
                end else begin
                    w_div_cnt_next = r_div_cnt + DIV_W'(1);
                end
            end

            DONE: begin
                w_state_next      = IDLE;
                w_done_next       = 1'b0;
                w_busy_next       = 1'b0;
                w_load_ready_next = 1'b1;
            end

            default: begin
                w_state_next      = IDLE;
                w_load_ready_next = 1'b0;
                w_ser_frame_next  = 1'b0;
                w_ser_data_next   = 1'b0;
                w_busy_next       = 1'b0;
                w_done_next       = 1'b0;
            end
        endcase
    end

endmodule
